// File: rtl/hdmi_video_tpg_if.sv
// Pixel-stream handshake between an upstream video source and the HDMI test pattern generator.
// The master offers pixels; the slave (the generator) accepts them with s_ready.
interface hdmi_video_tpg_if;
  logic [23:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/hdmi_video_tpg.sv
// HDMI video source: programmable raster timing generator feeding a pattern / passthrough pixel mux.
// Every video output is registered one clock behind the (h,v) counter state that produced it.
module hdmi_video_tpg #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  hdmi_video_tpg_if.slave     s,
  output logic                vout_hs,
  output logic                vout_vs,
  output logic                vout_de,
  output logic [23:0]         vout_data,
  output logic                frame_start,
  output logic [15:0]         frame_cnt,
  output logic                underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_IDLE = (HS_POL == 0) ? 1'b1 : 1'b0;
  localparam logic VS_IDLE = (VS_POL == 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] MODE_BARS = 2'd0;
  localparam logic [1:0] MODE_GRAD = 2'd1;
  localparam logic [1:0] MODE_PASS = 2'd2;
  localparam logic [1:0] MODE_BLK  = 2'd3;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0]    mode_q, mode_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;
  logic [23:0]   data_q, data_d;
  logic          fs_q, fs_d;
  logic          uf_q, uf_d;

  logic          origin;
  logic [1:0]    mode_eff;
  logic          de_i;
  logic          hs_i;
  logic          vs_i;
  logic          pass_i;
  logic [2:0]    bar_idx;
  logic [23:0]   bar_rgb;
  logic [23:0]   grad_rgb;
  logic [23:0]   pixel;

  // The mode requested at (0,0) already governs that first pixel, so the frame is uniform.
  always_comb begin
    origin   = en && (h_q == '0) && (v_q == '0);
    mode_eff = origin ? mode : mode_q;
    de_i     = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    hs_i     = (h_q >= HS_START) && (h_q < HS_END);
    vs_i     = (v_q >= VS_START) && (v_q < VS_END);
    pass_i   = en && de_i && (mode_eff == MODE_PASS);
  end

  assign s.s_ready = pass_i && !rst;

  always_comb begin
    bar_idx = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (h_q < HW'((i + 1) * BAR_W)) begin
        bar_idx = 3'(i);
      end
    end
  end

  always_comb begin
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    grad_rgb = {8'(h_q), 8'(v_q), 8'(h_q) ^ 8'(v_q)};
  end

  always_comb begin
    case (mode_eff)
      MODE_BARS: pixel = bar_rgb;
      MODE_GRAD: pixel = grad_rgb;
      MODE_PASS: pixel = s.s_valid ? s.s_data : 24'h000000;
      MODE_BLK:  pixel = 24'h000000;
      default:   pixel = 24'h000000;
    endcase
  end

  // Raster counters park at (0,0) while disabled so enabling always starts a fresh frame.
  always_comb begin
    h_d         = h_q;
    v_d         = v_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    if (!en) begin
      h_d = '0;
      v_d = '0;
    end else begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      if (origin) begin
        mode_d      = mode;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    de_d   = 1'b0;
    data_d = 24'h000000;
    hs_d   = HS_IDLE;
    vs_d   = VS_IDLE;
    fs_d   = 1'b0;
    uf_d   = 1'b0;
    if (en) begin
      de_d   = de_i;
      data_d = de_i ? pixel : 24'h000000;
      hs_d   = hs_i ? ~HS_IDLE : HS_IDLE;
      vs_d   = vs_i ? ~VS_IDLE : VS_IDLE;
      fs_d   = origin;
      uf_d   = pass_i && !s.s_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q         <= '0;
      v_q         <= '0;
      mode_q      <= MODE_BLK;
      frame_cnt_q <= 16'd0;
      hs_q        <= HS_IDLE;
      vs_q        <= VS_IDLE;
      de_q        <= 1'b0;
      data_q      <= 24'h000000;
      fs_q        <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
      data_q      <= data_d;
      fs_q        <= fs_d;
      uf_q        <= uf_d;
    end
  end

  assign vout_hs     = hs_q;
  assign vout_vs     = vs_q;
  assign vout_de     = de_q;
  assign vout_data   = data_q;
  assign frame_start = fs_q;
  assign frame_cnt   = frame_cnt_q;
  assign underflow   = uf_q;

endmodule
